// File: rtl/decoder_controller.sv
// Decode-path controller: walks the inverse round sub-blocks for NUM_ROUNDS rounds, rc_idx descending.
// Optional WATCHDOG_EN build aborts any wait state after WDOG_CYCLES cycles and flags err.
module decoder_controller #(
  parameter int NUM_ROUNDS  = 24,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ready_irc,
  input  logic       ready_irev,
  input  logic       ready_iper,
  input  logic       ready_irot,
  input  logic       ready_ipar,
  output logic       ready,
  output logic       start_irc,
  output logic       start_irev,
  output logic       start_iper,
  output logic       start_irot,
  output logic       start_ipar,
  output logic       ld_fr,
  output logic       ld_fw,
  output logic [4:0] rc_idx,
  output logic       err,
  output logic [3:0] ps,
  output logic [3:0] ns
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,  LOAD  = 4'd1,
    S_RC  = 4'd2,  W_RC  = 4'd3,
    S_REV = 4'd4,  W_REV = 4'd5,
    S_PER = 4'd6,  W_PER = 4'd7,
    S_ROT = 4'd8,  W_ROT = 4'd9,
    S_PAR = 4'd10, W_PAR = 4'd11,
    NEXT  = 4'd12, WRITE = 4'd13,
    DONE  = 4'd14
  } state_t;

  localparam logic [4:0] RC_INIT = 5'(NUM_ROUNDS - 1);

  state_t state, nxt;
  logic   wexp;

  assign ps = state;
  assign ns = nxt;

`ifdef WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;
  logic          err_q;
  logic          in_wait, wready;

  assign in_wait = state inside {W_RC, W_REV, W_PER, W_ROT, W_PAR};
  assign wexp    = (wcnt == WW'(WDOG_CYCLES - 1));
  assign err     = err_q;

  always_comb begin
    wready = 1'b0;
    case (state)
      W_RC:    wready = ready_irc;
      W_REV:   wready = ready_irev;
      W_PER:   wready = ready_iper;
      W_ROT:   wready = ready_irot;
      W_PAR:   wready = ready_ipar;
      default: wready = 1'b0;
    endcase
  end

  // Count is zero on the first cycle of every wait state, so expiry lands on cycle WDOG_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt <= in_wait ? wcnt + 1'b1 : '0;
      if (in_wait && !wready && wexp)
        err_q <= 1'b1;
      else if (state == DONE && !start)
        err_q <= 1'b0;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wexp        = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = S_RC;
      S_RC:    nxt = W_RC;
      W_RC:    if (ready_irc)  nxt = S_REV; else if (wexp) nxt = DONE;
      S_REV:   nxt = W_REV;
      W_REV:   if (ready_irev) nxt = S_PER; else if (wexp) nxt = DONE;
      S_PER:   nxt = W_PER;
      W_PER:   if (ready_iper) nxt = S_ROT; else if (wexp) nxt = DONE;
      S_ROT:   nxt = W_ROT;
      W_ROT:   if (ready_irot) nxt = S_PAR; else if (wexp) nxt = DONE;
      S_PAR:   nxt = W_PAR;
      W_PAR:   if (ready_ipar) nxt = NEXT;  else if (wexp) nxt = DONE;
      NEXT:    nxt = (rc_idx == 5'd0) ? WRITE : S_RC;
      WRITE:   nxt = DONE;
      DONE:    if (!start) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with ps without a comb path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rc_idx     <= RC_INIT;
      ready      <= 1'b0;
      start_irc  <= 1'b0;
      start_irev <= 1'b0;
      start_iper <= 1'b0;
      start_irot <= 1'b0;
      start_ipar <= 1'b0;
      ld_fr      <= 1'b0;
      ld_fw      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == NEXT && rc_idx != 5'd0)
        rc_idx <= rc_idx - 1'b1;
      else if (state == DONE && !start)
        rc_idx <= RC_INIT;
      ready      <= (nxt == DONE);
      start_irc  <= (nxt == S_RC);
      start_irev <= (nxt == S_REV);
      start_iper <= (nxt == S_PER);
      start_irot <= (nxt == S_ROT);
      start_ipar <= (nxt == S_PAR);
      ld_fr      <= (nxt == LOAD);
      ld_fw      <= (nxt == WRITE);
    end
  end

endmodule

// File: tb/tb_decoder_controller.sv
// Scoreboarded bench for decoder_controller: expected strobe sequence queued per decode, monitor pops.
module tb_decoder_controller;
  localparam int NR = 24;
  localparam int WD = 8;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0] rdy = 5'b0;
  logic       ready, start_irc, start_irev, start_iper, start_irot, start_ipar;
  logic       ld_fr, ld_fw, err;
  logic [4:0] rc_idx;
  logic [3:0] ps, ns;
  logic [4:0] strb;

  decoder_controller #(.NUM_ROUNDS(NR), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ready_irc(rdy[0]), .ready_irev(rdy[1]), .ready_iper(rdy[2]),
    .ready_irot(rdy[3]), .ready_ipar(rdy[4]),
    .ready(ready),
    .start_irc(start_irc), .start_irev(start_irev), .start_iper(start_iper),
    .start_irot(start_irot), .start_ipar(start_ipar),
    .ld_fr(ld_fr), .ld_fw(ld_fw), .rc_idx(rc_idx), .err(err),
    .ps(ps), .ns(ns)
  );

  assign strb = {start_ipar, start_irot, start_iper, start_irev, start_irc};

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int exp_q[$];
  // responder mode: 0 tied high, 1 pulse after delay, 2 level after delay, 3 stuck low
  int mode[5];
  int dly[5];
  int pend[5];
  int cnt[5];
  int n_wrev, n_srev;

  function automatic int ev(input int kind, input int r);
    return kind * 32 + r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cfg(input int m, input int d);
    for (int i = 0; i < 5; i++) begin
      mode[i] = m; dly[i] = d; pend[i] = 0; cnt[i] = 0;
    end
  endtask

  // Expected strobe order for one full decode of n rounds.
  task automatic push_decode(input int n);
    exp_q.push_back(ev(1, 0));
    for (int r = n - 1; r >= 0; r--) begin
      exp_q.push_back(ev(2, r));
      for (int k = 3; k <= 6; k++) exp_q.push_back(ev(k, 0));
    end
    exp_q.push_back(ev(7, 0));
    exp_q.push_back(ev(8, 0));
  endtask

  task automatic run_decode(output int lat, input int budget, input bit hold);
    n_wrev = 0; n_srev = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 1;
    while (ps != 4'd14 && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (ps == 4'd5) n_wrev++;
      if (start_irev) n_srev++;
    end
    if (ps != 4'd14) chk("done_timeout", int'(ps), 14);
  endtask

  task automatic finish_decode();
    @(posedge clk); #1;
    chk("done_to_idle_ps", int'(ps), 0);
    chk("rc_reload", int'(rc_idx), NR - 1);
    chk("idle_ready", int'(ready), 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // Sub-block models answer at the falling edge, seeing the start pulse one half-cycle earlier.
  initial begin : responder
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        case (mode[i])
          0: rdy[i] = 1'b1;
          3: rdy[i] = 1'b0;
          default: begin
            if (strb[i]) begin
              rdy[i] = 1'b0; pend[i] = 1;
              cnt[i] = (dly[i] < 0) ? int'($urandom_range(0, 3)) : dly[i];
            end else if (pend[i] != 0) begin
              if (cnt[i] == 0) begin rdy[i] = 1'b1; pend[i] = 0; end
              else cnt[i]--;
            end else if (mode[i] == 1) begin
              rdy[i] = 1'b0;
            end
          end
        endcase
      end
    end
  end

  initial begin : monitor
    int obs, nstb, e;
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      nstb = 0; obs = 0;
      if (ld_fr)      begin nstb++; obs = ev(1, 0); end
      if (start_irc)  begin nstb++; obs = ev(2, int'(rc_idx)); end
      if (start_irev) begin nstb++; obs = ev(3, 0); end
      if (start_iper) begin nstb++; obs = ev(4, 0); end
      if (start_irot) begin nstb++; obs = ev(5, 0); end
      if (start_ipar) begin nstb++; obs = ev(6, 0); end
      if (ld_fw)      begin nstb++; obs = ev(7, 0); end
      if (ready && !prev_ready) begin nstb++; obs = ev(8, 0); end
      prev_ready = ready;
      if (nstb > 1) begin
        checks++; fails++;
        $display("FAIL strobe_onehot: got %0d strobes in one cycle, want 1", nstb);
      end else if (nstb == 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got event %0d, want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (e != obs) begin
            fails++;
            $display("FAIL sb_event: got event %0d, want %0d", obs, e);
          end
        end
      end
    end
  end

  initial begin : driver
    int lat;
    cfg(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ps", int'(ps), 0);
    chk("rst_rc_idx", int'(rc_idx), NR - 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_strobes", int'({strb, ld_fr, ld_fw}), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", int'(ps), 0);

    // All sub-blocks answer in their first wait cycle.
    push_decode(NR);
    run_decode(lat, 2000, 1'b0);
    chk("latency_tied", lat, 11 * NR + 3);
    chk("done_ready", int'(ready), 1);
    chk("done_err", int'(err), 0);
    finish_decode();

    // Inverse revaluate answers 5 cycles late every round.
    cfg(0, 0); mode[1] = 1; dly[1] = 5;
    push_decode(NR);
    run_decode(lat, 2000, 1'b0);
    chk("latency_irev5", lat, 11 * NR + 3 + 5 * NR);
    chk("w_rev_cycles", n_wrev, 6 * NR);
    chk("start_irev_count", n_srev, NR);
    finish_decode();

    // Random delays, mixed pulse/level; first run keeps ready_ipar tied high.
    for (int k = 0; k < 4; k++) begin
      cfg(0, -1);
      for (int i = 0; i < 5; i++) mode[i] = int'($urandom_range(0, 2));
      if (k == 0) mode[4] = 0;
      push_decode(NR);
      run_decode(lat, 3000, 1'b0);
      chk("rand_err", int'(err), 0);
      chk("rand_latency_floor", int'(lat >= 11 * NR + 3), 1);
      finish_decode();
    end

    // Reset in round 10 while waiting on inverse permute.
    cfg(0, 0); mode[2] = 2; dly[2] = 2;
    push_decode(NR);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!(ps == 4'd7 && rc_idx == 5'(NR - 10)) && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
    chk("reach_w_per_r10", int'(ps), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ps", int'(ps), 0);
    chk("midrst_rc_idx", int'(rc_idx), NR - 1);
    chk("midrst_strobes", int'({strb, ld_fr, ld_fw, ready}), 0);
    exp_q.delete();
    rst = 1'b0;
    cfg(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", int'(ps), 0);
    push_decode(NR);
    run_decode(lat, 2000, 1'b0);
    chk("latency_after_rst", lat, 11 * NR + 3);
    finish_decode();

    // start held high through DONE: no auto-restart.
    push_decode(NR);
    run_decode(lat, 2000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("done_hold_ps", int'(ps), 14);
      chk("done_hold_ready", int'(ready), 1);
    end
    start = 1'b0;
    finish_decode();

    // ready_irot stuck low.
    cfg(0, 0); mode[3] = 3;
    exp_q.push_back(ev(1, 0));
    exp_q.push_back(ev(2, NR - 1));
    exp_q.push_back(ev(3, 0));
    exp_q.push_back(ev(4, 0));
    exp_q.push_back(ev(5, 0));
`ifdef WATCHDOG_EN
    exp_q.push_back(ev(8, 0));
    run_decode(lat, 500, 1'b0);
    chk("wdog_latency", lat, 9 + WD);
    chk("wdog_err", int'(err), 1);
    @(posedge clk); #1;
    chk("wdog_idle_ps", int'(ps), 0);
    chk("wdog_err_clear", int'(err), 0);
    chk("sb_drained", exp_q.size(), 0);
`else
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("stuck_w_rot", int'(ps), 9);
    chk("stuck_err", int'(err), 0);
    chk("sb_drained", exp_q.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("stuck_rst_ps", int'(ps), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
